// File: rtl/ysyx_22041752_ifetch_ctrl_pkg.sv
// Shared definitions for the pre-IF fetch controller: state encoding and reset PC.
package ysyx_22041752_ifetch_ctrl_pkg;

  typedef enum logic [2:0] {
    PF_IDLE = 3'd0,
    PF_REQ  = 3'd1,
    PF_WAIT = 3'd2,
    PF_HOLD = 3'd3,
    PF_DROP = 3'd4
  } pf_state_t;

  localparam logic [31:0] PF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22041752_ifetch_ctrl_slot_sel.sv
// Picks one instruction slot out of a two-slot memory word; an erroring response yields zero.
module ysyx_22041752_ifetch_ctrl_slot_sel #(
  parameter int unsigned DATA_WD = 64,
  parameter int unsigned INST_WD = 32
) (
  input  logic [DATA_WD-1:0] data,
  input  logic               sel,
  input  logic               err,
  output logic [INST_WD-1:0] inst
);

  always_comb begin
    inst = '0;
    if (!err) begin
      inst = sel ? data[2*INST_WD-1:INST_WD] : data[INST_WD-1:0];
    end
  end

endmodule

// File: rtl/ysyx_22041752_ifetch_ctrl.sv
// Pre-IF fetch controller: one outstanding instruction read, buffered hand-off to the
// fetch stage, and flush handling that discards the response of any abandoned request.
import ysyx_22041752_ifetch_ctrl_pkg::*;

module ysyx_22041752_ifetch_ctrl #(
  parameter int unsigned     ADDR_WD  = 32,
  parameter int unsigned     DATA_WD  = 64,
  parameter int unsigned     INST_WD  = 32,
  parameter int unsigned     PC_WD    = 32,
  parameter logic [PC_WD-1:0] RESET_PC = PF_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fs_allowin,
  input  logic [PC_WD-1:0]   fs_nextpc,
  input  logic               flush,
  input  logic [PC_WD-1:0]   flush_pc,
  output logic               pf_to_fs_valid,
  output logic [INST_WD-1:0] pf_inst,
  output logic [PC_WD-1:0]   pf_pc,
  output logic               pf_fault,
  output logic               req_valid,
  output logic [ADDR_WD-1:0] req_addr,
  input  logic               req_ready,
  input  logic               resp_valid,
  input  logic [DATA_WD-1:0] resp_data,
  input  logic               resp_err,
  output logic               resp_ready
);

  pf_state_t           state, state_next;
  logic [PC_WD-1:0]    pc, pc_next;
  logic [INST_WD-1:0]  inst_buf, slot_inst;
  logic                fault_buf;
  logic                drop_pend, drop_pend_next;
  logic                capture;
  logic [ADDR_WD-1:2]  req_word;

  ysyx_22041752_ifetch_ctrl_slot_sel #(
    .DATA_WD (DATA_WD),
    .INST_WD (INST_WD)
  ) u_slot_sel (
    .data (resp_data),
    .sel  (pc[2]),
    .err  (resp_err),
    .inst (slot_inst)
  );

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    drop_pend_next = drop_pend;
    capture        = 1'b0;
    req_valid      = 1'b0;
    resp_ready     = 1'b0;
    pf_to_fs_valid = 1'b0;
    unique case (state)
      PF_IDLE: state_next = PF_REQ;
      PF_REQ: begin
        req_valid = 1'b1;
        if (flush) pc_next = flush_pc;
        if (req_ready) begin
          state_next = (flush || drop_pend) ? PF_DROP : PF_WAIT;
        end else if (flush) begin
          drop_pend_next = 1'b1;
        end
      end
      PF_WAIT: begin
        resp_ready = 1'b1;
        if (flush) begin
          pc_next    = flush_pc;
          state_next = resp_valid ? PF_REQ : PF_DROP;
        end else if (resp_valid) begin
          capture    = 1'b1;
          state_next = PF_HOLD;
        end
      end
      PF_DROP: begin
        resp_ready     = 1'b1;
        drop_pend_next = 1'b0;
        if (flush) pc_next = flush_pc;
        if (resp_valid) state_next = PF_REQ;
      end
      PF_HOLD: begin
        pf_to_fs_valid = !flush;
        if (flush) begin
          pc_next    = flush_pc;
          state_next = PF_REQ;
        end else if (fs_allowin) begin
          pc_next    = fs_nextpc;
          state_next = PF_REQ;
        end
      end
      default: state_next = PF_IDLE;
    endcase
  end

  // The request address is frozen while REQ is waiting for req_ready, even if a
  // flush has already moved pc; everywhere else it tracks the next pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PF_IDLE;
      pc        <= RESET_PC;
      inst_buf  <= '0;
      fault_buf <= 1'b0;
      drop_pend <= 1'b0;
      req_word  <= RESET_PC[ADDR_WD-1:2];
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      drop_pend <= drop_pend_next;
      if (state != PF_REQ) req_word <= pc_next[ADDR_WD-1:2];
      if (capture) begin
        inst_buf  <= slot_inst;
        fault_buf <= resp_err;
      end
    end
  end

  assign req_addr = {req_word, 2'b00};
  assign pf_inst  = inst_buf;
  assign pf_fault = fault_buf;
  assign pf_pc    = pc;

endmodule
